// File: rtl/softmax_pkg.sv
// Shared constants for the row-softmax scheduler: element format, FSM encoding
// and the row-width helper.
package softmax_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int Q_FRAC_BITS = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    function automatic int row_w(input int cols, input int data_w);
        return cols * data_w;
    endfunction

endpackage

// File: rtl/softmax_row_credit.sv
// In-flight row counter: +1 per accepted beat, -1 per returned row, and the
// credit test used to decide whether another beat may be loaded.
module softmax_row_credit #(
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             accept,
    input  logic             ret,
    output logic [CNT_W-1:0] inflight,
    output logic             credit_ok
);

    logic [CNT_W-1:0] inflight_r;

    // Counter update; a simultaneous accept and return leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            inflight_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept, ret})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign inflight  = inflight_r;
    // A beat accepted this cycle already consumes a credit
    assign credit_ok = (32'(inflight_r) + 32'(accept)) < 32'(MAX_INFLIGHT);

endmodule

// File: rtl/softmax_matrix_sched.sv
// Streams matrix rows into an external row-softmax engine under a credit
// limit and reassembles the returned rows, with abort/drain and error flag.
module softmax_matrix_sched
    import softmax_pkg::*;
#(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_INFLIGHT = 8,
    localparam int CNT_W       = $clog2(ROWS + 1),
    localparam int ROW_W       = row_w(COLS, DATA_W),
    localparam int MAT_W       = ROWS * ROW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_rows,
    input  logic [MAT_W-1:0] matrix_i,
    output logic [MAT_W-1:0] matrix_o,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             eng_valid_o,
    input  logic             eng_ready_i,
    output logic [ROW_W-1:0] eng_row_o,
    input  logic             eng_valid_i,
    input  logic [ROW_W-1:0] eng_row_i
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] nr_r;
    logic [CNT_W-1:0] send_idx_r;
    logic [CNT_W-1:0] recv_idx_r;
    logic [CNT_W-1:0] inflight_s;
    logic [CNT_W-1:0] nr_start_s;
    logic [CNT_W-1:0] send_nxt_s;
    logic [CNT_W-1:0] load_idx_s;
    logic             accept_s;
    logic             ret_s;
    logic             credit_ok_s;
    logic             start_go_s;
    logic             last_cap_s;
    logic             issue_s;
    logic             load_s;
    logic             valid_nxt_s;
    logic             done_nxt_s;
    logic             err_set_s;
    logic             eng_valid_r;
    logic             done_r;
    logic             err_r;
    logic [ROW_W-1:0] eng_row_r;
    logic [MAT_W-1:0] matrix_r;

    assign accept_s   = eng_valid_r & eng_ready_i;
    assign ret_s      = eng_valid_i & (inflight_s != {CNT_W{1'b0}}) & (state_r != ST_IDLE);
    assign send_nxt_s = send_idx_r + CNT_W'(accept_s);
    assign last_cap_s = (state_r == ST_RUN) & ret_s & (recv_idx_r == (nr_r - CNT_W'(1)));

    softmax_row_credit #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .CNT_W        (CNT_W)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_go_s),
        .accept    (accept_s),
        .ret       (ret_s),
        .inflight  (inflight_s),
        .credit_ok (credit_ok_s)
    );

    // Requested row count clamped to the matrix height
    always_comb begin
        if (n_rows > CNT_W'(ROWS)) begin
            nr_start_s = CNT_W'(ROWS);
        end else begin
            nr_start_s = n_rows;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; completion of the last row takes precedence over abort
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (nr_start_s != {CNT_W{1'b0}})) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_cap_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (abort) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((inflight_s == {CNT_W{1'b0}}) || ((inflight_s == CNT_W'(1)) && ret_s)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output/strobe decode feeding the registered outputs
    always_comb begin
        start_go_s = (state_r == ST_IDLE) & start;
        issue_s    = (state_r == ST_RUN) & ~abort & (~eng_valid_r | accept_s)
                   & (send_nxt_s < nr_r) & credit_ok_s;
        if (start_go_s) begin
            load_s     = (nr_start_s != {CNT_W{1'b0}});
            load_idx_s = {CNT_W{1'b0}};
        end else begin
            load_s     = issue_s;
            load_idx_s = send_nxt_s;
        end
        if (load_s) begin
            valid_nxt_s = 1'b1;
        end else if ((state_r == ST_RUN) && !abort && !accept_s) begin
            valid_nxt_s = eng_valid_r;
        end else begin
            valid_nxt_s = 1'b0;
        end
        done_nxt_s = (start_go_s & (nr_start_s == {CNT_W{1'b0}})) | last_cap_s;
        err_set_s  = eng_valid_i & ~ret_s;
    end

    // Issue side: beat register, handshake and send index
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_valid_r <= 1'b0;
            eng_row_r   <= {ROW_W{1'b0}};
            nr_r        <= {CNT_W{1'b0}};
            send_idx_r  <= {CNT_W{1'b0}};
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            eng_valid_r <= valid_nxt_s;
            done_r      <= done_nxt_s;
            if (load_s) begin
                eng_row_r <= matrix_i[int'(load_idx_s)*ROW_W +: ROW_W];
            end
            if (start_go_s) begin
                nr_r       <= nr_start_s;
                send_idx_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_RUN) begin
                send_idx_r <= send_nxt_s;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (start_go_s) begin
                err_r <= 1'b0;
            end
        end
    end

    // Receive side: rows come back in issue order and land at recv_idx
    always_ff @(posedge clk) begin
        if (rst) begin
            recv_idx_r <= {CNT_W{1'b0}};
            matrix_r   <= {MAT_W{1'b0}};
        end else if (start_go_s) begin
            recv_idx_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_RUN) && ret_s) begin
            matrix_r[int'(recv_idx_r)*ROW_W +: ROW_W] <= eng_row_i;
            recv_idx_r <= recv_idx_r + CNT_W'(1);
        end
    end

    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;
    assign err         = err_r;
    assign eng_valid_o = eng_valid_r;
    assign eng_row_o   = eng_row_r;
    assign matrix_o    = matrix_r;

endmodule

// File: tb/tb_softmax_matrix_sched.sv
// Self-checking bench: a latency-L engine stub (each element +1) in a queue and
// a matrix-level reference model of what matrix_o should hold after each job.
module tb_softmax_matrix_sched;

    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int DATA_W  = 16;
    localparam int MAX_INF = 8;
    localparam int CNT_W   = $clog2(ROWS + 1);
    localparam int ROW_W   = COLS * DATA_W;
    localparam int MAT_W   = ROWS * ROW_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] n_rows = '0;
    logic [MAT_W-1:0] mat_in = '0;
    logic [MAT_W-1:0] matrix_o;
    logic             busy, done, err, eng_valid_o;
    logic             eng_ready_i = 1'b0;
    logic [ROW_W-1:0] eng_row_o;
    logic             eng_valid_i = 1'b0;
    logic [ROW_W-1:0] eng_row_i = '0;

    softmax_matrix_sched #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INF)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_rows(n_rows),
        .matrix_i(mat_in), .matrix_o(matrix_o), .busy(busy), .done(done), .err(err),
        .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i), .eng_row_o(eng_row_o),
        .eng_valid_i(eng_valid_i), .eng_row_i(eng_row_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ROW_W-1:0] d; int due; } ret_t;
    ret_t eq[$];

    int n_chk = 0, n_pass = 0;
    logic [MAT_W-1:0] exp_mat = '0;
    int cyc, done_cnt, done_cyc, first_valid, busy_first, busy_last, busy_cnt;
    int max_inf, infl, acc_cnt, seq_err, stab_err, valid_after_abort, last_due;

    function automatic logic [ROW_W-1:0] row_of(input logic [MAT_W-1:0] m, input int r);
        return m[r*ROW_W +: ROW_W];
    endfunction

    function automatic logic [ROW_W-1:0] inc_row(input logic [ROW_W-1:0] x);
        logic [ROW_W-1:0] y;
        for (int c = 0; c < COLS; c++) y[c*DATA_W +: DATA_W] = x[c*DATA_W +: DATA_W] + DATA_W'(1);
        return y;
    endfunction

    task automatic rand_matrix();
        for (int i = 0; i < MAT_W / 32; i++) mat_in[i*32 +: 32] = $urandom();
    endtask

    // Runs one job for ncyc cycles; start before edge 0, abort/restart at given edges
    task automatic run_job(input int nreq, input int lat, input int rmode,
                           input int abort_at, input int restart_at, input int ncyc);
        int  nr_eff;
        logic acc;
        nr_eff = (nreq > ROWS) ? ROWS : nreq;
        eq.delete();
        done_cnt = 0; done_cyc = -1; first_valid = -1; busy_first = -1; busy_last = -1;
        busy_cnt = 0; max_inf = 0; infl = 0; acc_cnt = 0; seq_err = 0; stab_err = 0;
        valid_after_abort = 0; last_due = -1;
        n_rows = nreq[CNT_W-1:0];
        cyc = 0;
        for (int k = 0; k < ncyc; k++) begin
            logic             hold;
            logic [ROW_W-1:0] held_row;
            start = (cyc == 0) || (cyc == restart_at);
            abort = (cyc == abort_at);
            case (rmode)
                0:       eng_ready_i = 1'b1;
                1:       eng_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: eng_ready_i = 1'($urandom_range(0, 1));
            endcase
            acc = eng_valid_o & eng_ready_i;
            if (acc) begin
                if (acc_cnt >= nr_eff) seq_err++;
                else if (eng_row_o !== row_of(mat_in, acc_cnt)) seq_err++;
                eq.push_back('{d: inc_row(eng_row_o), due: cyc + lat});
                last_due = cyc + lat;
                acc_cnt++;
                infl++;
            end
            if (eng_valid_i && infl > 0) infl--;
            if (infl > max_inf) max_inf = infl;
            hold     = eng_valid_o & ~eng_ready_i & ~abort;
            held_row = eng_row_o;
            @(posedge clk);
            cyc++;
            #1;
            if (hold && (eng_valid_o !== 1'b1 || eng_row_o !== held_row)) stab_err++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (eng_valid_o && first_valid < 0) first_valid = cyc;
            if (abort_at >= 0 && cyc > abort_at && eng_valid_o) valid_after_abort++;
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
            if (eq.size() > 0 && eq[0].due == cyc) begin
                eng_valid_i = 1'b1;
                eng_row_i   = eq[0].d;
                void'(eq.pop_front());
            end else begin
                eng_valid_i = 1'b0;
                eng_row_i   = '0;
            end
        end
        start = 1'b0; abort = 1'b0; eng_valid_i = 1'b0; eng_row_i = '0;
    endtask

    task automatic test_reset();
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
        n_chk++; if (eng_valid_o !== 1'b0) $display("FAIL reset_valid got %b exp 0", eng_valid_o); else n_pass++;
        n_chk++; if (matrix_o !== '0) $display("FAIL reset_matrix got nonzero exp 0 (row0 %h)", row_of(matrix_o, 0)); else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_full();
        rand_matrix();
        run_job(16, 5, 0, -1, -1, 30);
        n_chk++; if (first_valid !== 1) $display("FAIL full_first_valid got %0d exp 1", first_valid); else n_pass++;
        n_chk++; if (done_cyc !== 22) $display("FAIL full_done_cyc got %0d exp 22", done_cyc); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL full_done_cnt got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (busy_first !== 1 || busy_last !== 21 || busy_cnt !== 21)
            $display("FAIL full_busy got %0d..%0d (%0d) exp 1..21 (21)", busy_first, busy_last, busy_cnt); else n_pass++;
        n_chk++; if (seq_err !== 0) $display("FAIL full_seq got %0d exp 0", seq_err); else n_pass++;
        n_chk++; if (err !== 1'b0) $display("FAIL full_err got %b exp 0", err); else n_pass++;
        for (int r = 0; r < ROWS; r++) exp_mat[r*ROW_W +: ROW_W] = inc_row(row_of(mat_in, r));
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL full_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
    endtask

    task automatic test_partial();
        rand_matrix();
        run_job(3, 5, 0, -1, -1, 14);
        n_chk++; if (done_cyc !== 9) $display("FAIL part_done_cyc got %0d exp 9", done_cyc); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL part_done_cnt got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (acc_cnt !== 3) $display("FAIL part_beats got %0d exp 3", acc_cnt); else n_pass++;
        for (int r = 0; r < 3; r++) exp_mat[r*ROW_W +: ROW_W] = inc_row(row_of(mat_in, r));
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL part_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
        rand_matrix();
        run_job(0, 5, 0, -1, -1, 6);
        n_chk++; if (done_cyc !== 1) $display("FAIL zero_done_cyc got %0d exp 1", done_cyc); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL zero_done_cnt got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (first_valid !== -1) $display("FAIL zero_valid got cycle %0d exp never", first_valid); else n_pass++;
        n_chk++; if (busy_cnt !== 0) $display("FAIL zero_busy got %0d exp 0", busy_cnt); else n_pass++;
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL zero_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
    endtask

    task automatic test_credit();
        rand_matrix();
        run_job(16, 12, 0, -1, -1, 70);
        n_chk++; if (max_inf !== MAX_INF) $display("FAIL credit_max got %0d exp %0d", max_inf, MAX_INF); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL credit_done got %0d exp 1", done_cnt); else n_pass++;
        n_chk++; if (seq_err !== 0) $display("FAIL credit_seq got %0d exp 0", seq_err); else n_pass++;
        for (int r = 0; r < ROWS; r++) exp_mat[r*ROW_W +: ROW_W] = inc_row(row_of(mat_in, r));
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL credit_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        rand_matrix();
        run_job(16, 3, 1, -1, -1, 90);
        n_chk++; if (stab_err !== 0) $display("FAIL bp_stable got %0d exp 0", stab_err); else n_pass++;
        n_chk++; if (seq_err !== 0) $display("FAIL bp_seq got %0d exp 0", seq_err); else n_pass++;
        n_chk++; if (acc_cnt !== 16) $display("FAIL bp_beats got %0d exp 16", acc_cnt); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL bp_done got %0d exp 1", done_cnt); else n_pass++;
        for (int r = 0; r < ROWS; r++) exp_mat[r*ROW_W +: ROW_W] = inc_row(row_of(mat_in, r));
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL bp_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
    endtask

    task automatic test_abort();
        rand_matrix();
        run_job(16, 8, 0, 5, 7, 30);
        n_chk++; if (valid_after_abort !== 0) $display("FAIL abort_valid got %0d exp 0", valid_after_abort); else n_pass++;
        n_chk++; if (acc_cnt !== 5) $display("FAIL abort_beats got %0d exp 5", acc_cnt); else n_pass++;
        n_chk++; if (done_cnt !== 0) $display("FAIL abort_done got %0d exp 0", done_cnt); else n_pass++;
        n_chk++; if (busy_last !== last_due || busy_cnt !== last_due)
            $display("FAIL abort_busy got last %0d cnt %0d exp %0d", busy_last, busy_cnt, last_due); else n_pass++;
        n_chk++; if (eq.size() !== 0) $display("FAIL abort_pending got %0d exp 0", eq.size()); else n_pass++;
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL abort_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
    endtask

    task automatic test_error();
        eng_valid_i = 1'b1;
        eng_row_i   = {ROW_W/32{$urandom()}};
        @(posedge clk); #1;
        eng_valid_i = 1'b0;
        eng_row_i   = '0;
        n_chk++; if (err !== 1'b1) $display("FAIL err_set got %b exp 1", err); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL err_busy got %b exp 0", busy); else n_pass++;
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                $display("FAIL err_row%0d got %h exp %h", r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
        end
        run_job(0, 1, 0, -1, -1, 3);
        n_chk++; if (err !== 1'b0) $display("FAIL err_clear got %b exp 0", err); else n_pass++;
        n_chk++; if (done_cnt !== 1) $display("FAIL err_done got %0d exp 1", done_cnt); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int nr, lat, ne;
            nr  = $urandom_range(1, 20);
            lat = $urandom_range(1, 10);
            ne  = (nr > ROWS) ? ROWS : nr;
            rand_matrix();
            run_job(nr, lat, 2, -1, -1, 400);
            n_chk++; if (done_cnt !== 1) $display("FAIL rnd%0d_done got %0d exp 1", it, done_cnt); else n_pass++;
            n_chk++; if (seq_err !== 0 || stab_err !== 0)
                $display("FAIL rnd%0d_order got seq %0d stab %0d exp 0 0", it, seq_err, stab_err); else n_pass++;
            n_chk++; if (acc_cnt !== ne) $display("FAIL rnd%0d_beats got %0d exp %0d", it, acc_cnt, ne); else n_pass++;
            n_chk++; if (max_inf > MAX_INF) $display("FAIL rnd%0d_credit got %0d exp <=%0d", it, max_inf, MAX_INF); else n_pass++;
            n_chk++; if (err !== 1'b0) $display("FAIL rnd%0d_err got %b exp 0", it, err); else n_pass++;
            for (int r = 0; r < ne; r++) exp_mat[r*ROW_W +: ROW_W] = inc_row(row_of(mat_in, r));
            for (int r = 0; r < ROWS; r++) begin
                n_chk++; if (row_of(matrix_o, r) !== row_of(exp_mat, r))
                    $display("FAIL rnd%0d_row%0d got %h exp %h", it, r, row_of(matrix_o, r), row_of(exp_mat, r)); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_matrix();
        run_job(16, 5, 0, -1, -1, 8);
        rst = 1'b1;
        eq.delete();
        @(posedge clk); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else n_pass++;
        n_chk++; if (eng_valid_o !== 1'b0) $display("FAIL rmid_valid got %b exp 0", eng_valid_o); else n_pass++;
        n_chk++; if (eng_row_o !== '0) $display("FAIL rmid_row got %h exp 0", eng_row_o); else n_pass++;
        n_chk++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rmid_flags got %b%b exp 00", done, err); else n_pass++;
        for (int r = 0; r < ROWS; r++) begin
            n_chk++; if (row_of(matrix_o, r) !== '0)
                $display("FAIL rmid_row%0d got %h exp 0", r, row_of(matrix_o, r)); else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_full();
        test_partial();
        test_credit();
        test_backpressure();
        test_abort();
        test_error();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
